memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
- Shares one single-port synchronous memory between NUM_REQ requesters, e.g. requester 0 = load/store unit and requester 1 = instruction fetch.
- Each requester uses a valid/ready request channel and a response channel.
- Round-robin arbitration grants at most one access per cycle and drives the memory master signals: read_data in; write_data, address, write_enable, enable, byte_enable out.
- Read data is returned to the originating requester after a fixed memory latency, tracked by an in-flight tag pipeline.

Parameters:
- DATA_WIDTH, 32, memory word width; must be a multiple of 8.
- ADDR_WIDTH, 16, memory word address width.
- NUM_REQ, 2, number of requesters; legal range 2..4.
- READ_LATENCY, 1, cycles from accept edge to read data valid on mem_read_data; legal range 1..4.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_address  in  NUM_REQ x ADDR_WIDTH  request address.
- req_write_enable  in  NUM_REQ  1 = write, 0 = read.
- req_write_data  in  NUM_REQ x DATA_WIDTH  write data.
- req_byte_enable  in  NUM_REQ x DATA_WIDTH/8  byte lanes.
- rsp_valid  out  NUM_REQ  one-cycle read-data-valid pulse per requester.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters; qualified by rsp_valid.
- mem_read_data  in  DATA_WIDTH  memory read data.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_write_enable  out  1  memory write strobe.
- mem_enable  out  DATA_WIDTH/8  per-byte memory enable.
- mem_byte_enable  out  DATA_WIDTH/8  memory byte lanes.

Behaviour:
- **Clock and reset.** One clock, clk. reset is asynchronous and active-high.
- **Reset values.**
  - Priority pointer = 0.
  - Tag pipeline cleared; rsp_valid = 0.
  - All mem_* outputs = 0 and req_ready = 0 while reset is asserted.
- **Arbitration (combinational).**
  - Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
  - The first requester with req_valid = 1 receives req_ready = 1; all others see 0.
  - If no requester is valid, req_ready = 0.
- **Accept.** An accept occurs when req_valid[i] & req_ready[i]. In the same cycle, the mem_* outputs combinationally mirror requester i:
  - mem_address = req_address[i]
  - mem_write_data = req_write_data[i]
  - mem_write_enable = req_write_enable[i]
  - mem_byte_enable = req_byte_enable[i]
  - mem_enable = req_byte_enable[i]
- **Idle cycle.** All mem_* outputs = 0; no memory access occurs.
- **Pointer update.** On the clock edge after an accept by i, pointer <= (i+1) mod NUM_REQ. The pointer holds when there is no accept. Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- **Requester rules (checked by assertion, not corrected).**
  - Payload must be held stable while req_valid = 1 and req_ready = 0.
  - req_valid must not drop before accept.
- **Tag pipeline.**
  - A shift register of depth READ_LATENCY, each stage holding {valid, id}.
  - Stage 0 loads {accept & ~req_write_enable[i], i} at every edge.
- **Read response.**
  - rsp_valid[id] = 1 in exactly the cycle the last stage is valid; this is READ_LATENCY cycles after the accept edge.
  - rsp_data = mem_read_data combinationally in that cycle.
  - rsp_data is 0 when no response is pending.
- **Writes.** Writes produce no response. A write takes effect at the accept edge.
- **Back-to-back accepts.** Accepts are allowed in every cycle; throughput is one access per cycle. Responses return in accept order.
- **Simultaneous events.**
  - A new accept and a response in the same cycle are independent.
  - A read followed immediately by a write to the same address returns pre-write data; this is the memory's read-first behaviour and is passed through.
- **Reset mid-operation.** In-flight reads are discarded; no rsp_valid pulse is produced after reset deasserts.
- **Parameter checks.** Elaboration-time error if NUM_REQ or READ_LATENCY is out of range, or if DATA_WIDTH % 8 != 0.

Decomposition:
- **Shared package mem_arb_pkg:**
  - MAX_REQ = 4
  - req_id_t = logic [$clog2(MAX_REQ)-1:0]
  - rsp_tag_t struct {valid, id}
- **Sub-module rr_arbiter:**
  - Owns the round-robin pick and the priority pointer register.
  - Inputs: req vector and accept.
  - Outputs: one-hot grant and encoded id.
  - The top level holds the payload mux and the tag pipeline.

Test Plan:
- Reset, then req_valid = 2'b01, read addr 0x0010, mem returns 0xDEADBEEF (READ_LATENCY = 1) -> req_ready = 2'b01 same cycle; mem_enable = 4'hF; rsp_valid = 2'b01 with rsp_data = 0xDEADBEEF one cycle later.
- Both requesters hold reads continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp_valid follows the same sequence with 1-cycle lag.
- Requester 1 writes 0x12345678 to 0x0020 with byte_enable 4'b0011 -> mem_write_enable = 1, mem_byte_enable = 4'b0011, no rsp_valid; a later read of 0x0020 returns 0x????5678 with upper bytes unchanged.
- READ_LATENCY = 3, reads by requester 0 at cycle 0 and requester 1 at cycle 1 -> rsp_valid[0] at cycle 3, rsp_valid[1] at cycle 4.
- Read accepted, reset asserted for 1 cycle before data returns -> no rsp_valid pulse after deassert; pointer = 0; all outputs 0 during reset.
- Requester 0 valid alone for 3 cycles with pointer = 1 -> granted every cycle; no idle bubble.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

    localparam int MAX_REQ  = 4;
    localparam int ID_WIDTH = $clog2(MAX_REQ);

    typedef logic [ID_WIDTH-1:0] req_id_t;

    // One stage of the in-flight read tracker.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_tag_t;

    // Successor of a requester id, wrapping at num_req.
    function automatic req_id_t next_id(input req_id_t id, input int num_req);
        if (int'(id) >= num_req - 1) begin
            return '0;
        end
        return id + req_id_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among valid requesters, starting at the priority pointer.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output req_id_t            o_grant_id
);

    req_id_t r_ptr;
    req_id_t w_cand;
    req_id_t w_id;
    logic    w_found;

    // Walk the candidates ptr, ptr+1, ... and take the first valid one.
    always_comb begin
        w_cand  = r_ptr;
        w_found = 1'b0;
        w_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && i_req[i] && (req_id_t'(i) == w_cand)) begin
                    w_found = 1'b1;
                    w_id    = w_cand;
                end
            end
            w_cand = next_id(w_cand, NUM_REQ);
        end
    end

    // Expand the winning id into a one-hot grant.
    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = w_found && (w_id == req_id_t'(i));
        end
    end

    assign o_grant_id = w_id;

    // Pointer moves past the winner only when an access is actually taken.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= next_id(w_id, NUM_REQ);
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port synchronous memory among NUM_REQ requesters and
// routes read data back to the requester that issued the read.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    output logic [NUM_REQ-1:0]                     o_req_ready,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     i_req_address,
    input  logic [NUM_REQ-1:0]                     i_req_write_enable,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     i_req_write_data,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   i_req_byte_enable,
    output logic [NUM_REQ-1:0]                     o_rsp_valid,
    output logic [DATA_WIDTH-1:0]                  o_rsp_data,
    input  logic [DATA_WIDTH-1:0]                  i_mem_read_data,
    output logic [DATA_WIDTH-1:0]                  o_mem_write_data,
    output logic [ADDR_WIDTH-1:0]                  o_mem_address,
    output logic                                   o_mem_write_enable,
    output logic [DATA_WIDTH/8-1:0]                o_mem_enable,
    output logic [DATA_WIDTH/8-1:0]                o_mem_byte_enable
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("memory_port_arbiter: NUM_REQ must be 2..4");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("memory_port_arbiter: READ_LATENCY must be 1..4");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("memory_port_arbiter: DATA_WIDTH must be a multiple of 8");
    end

    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    w_ready;
    req_id_t               w_grant_id;
    logic                  w_accept;
    logic                  w_is_read;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_we;
    logic [BE_WIDTH-1:0]   w_be;
    rsp_tag_t              r_tag [READ_LATENCY];
    rsp_tag_t              w_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (i_req_valid),
        .i_accept   (w_accept),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    // No grants are visible while reset is held.
    assign w_ready     = i_reset ? '0 : w_grant;
    assign w_accept    = |w_ready;
    assign o_req_ready = w_ready;

    // Payload mux: memory outputs mirror the granted requester, zero when idle.
    always_comb begin
        w_addr    = '0;
        w_wdata   = '0;
        w_we      = 1'b0;
        w_be      = '0;
        w_is_read = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i]) begin
                w_addr    = i_req_address[i];
                w_wdata   = i_req_write_data[i];
                w_we      = i_req_write_enable[i];
                w_be      = i_req_byte_enable[i];
                w_is_read = ~i_req_write_enable[i];
            end
        end
    end

    assign o_mem_address      = w_addr;
    assign o_mem_write_data   = w_wdata;
    assign o_mem_write_enable = w_we;
    assign o_mem_byte_enable  = w_be;
    assign o_mem_enable       = w_be;

    // Tag pipeline tracks which requester owns the read data in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_is_read, id: w_grant_id};
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_last     = r_tag[READ_LATENCY-1];
    assign o_rsp_data = w_last.valid ? i_mem_read_data : '0;

    // Route the response pulse to the owner of the returning read.
    always_comb begin
        o_rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_rsp_valid[i] = w_last.valid && (w_last.id == req_id_t'(i));
        end
    end

    // A waiting requester must keep its request and payload steady until granted.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_rules
        a_hold_request: assert property (@(posedge i_clk) disable iff (i_reset)
            (i_req_valid[g] && !w_ready[g]) |=>
                (i_req_valid[g] &&
                 $stable(i_req_address[g]) &&
                 $stable(i_req_write_enable[g]) &&
                 $stable(i_req_write_data[g]) &&
                 $stable(i_req_byte_enable[g])));
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Random and directed stimulus against a queue-based reference model; two
// instances share the stimulus, one with read latency 1 and one with 3.
module tb_memory_port_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        v;
    logic [1:0][15:0]  addr;
    logic [1:0]        we;
    logic [1:0][31:0]  wd;
    logic [1:0][3:0]   be;

    logic [1:0]  a_ready, a_rv;
    logic [31:0] a_rdata, a_mrd, a_mwd;
    logic [15:0] a_maddr;
    logic        a_mwe;
    logic [3:0]  a_men, a_mbe;

    logic [1:0]  b_ready, b_rv;
    logic [31:0] b_rdata, b_mrd, b_mwd;
    logic [15:0] b_maddr;
    logic        b_mwe;
    logic [3:0]  b_men, b_mbe;

    int n_chk;
    int n_err;
    int ptr;
    int cyc;
    int last_g;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] shadow [int];
    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];

    logic [1:0]  obs_ar, obs_arv, obs_brv;
    logic [31:0] obs_ard;
    logic [3:0]  obs_amen, obs_ambe;
    logic        obs_amwe;

    memory_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_REQ(2), .READ_LATENCY(1)) u_dut_l1 (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(v), .o_req_ready(a_ready), .i_req_address(addr),
        .i_req_write_enable(we), .i_req_write_data(wd), .i_req_byte_enable(be),
        .o_rsp_valid(a_rv), .o_rsp_data(a_rdata), .i_mem_read_data(a_mrd),
        .o_mem_write_data(a_mwd), .o_mem_address(a_maddr), .o_mem_write_enable(a_mwe),
        .o_mem_enable(a_men), .o_mem_byte_enable(a_mbe)
    );

    memory_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_REQ(2), .READ_LATENCY(3)) u_dut_l3 (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(v), .o_req_ready(b_ready), .i_req_address(addr),
        .i_req_write_enable(we), .i_req_write_data(wd), .i_req_byte_enable(be),
        .o_rsp_valid(b_rv), .o_rsp_data(b_rdata), .i_mem_read_data(b_mrd),
        .o_mem_write_data(b_mwd), .o_mem_address(b_maddr), .o_mem_write_enable(b_mwe),
        .o_mem_enable(b_men), .o_mem_byte_enable(b_mbe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return 32'hA5000000 ^ (32'(a) * 32'h00010203);
    endfunction

    // Read-first memory with 1-cycle read latency for the first instance.
    always @(posedge clk) begin
        logic [31:0] w;
        int          ad;
        ad = int'(a_maddr[7:0]);
        w  = mem_a.exists(ad) ? mem_a[ad] : init_word(ad);
        pipe_a <= (a_men != 4'h0) ? w : 32'h0;
        if (a_men != 4'h0 && a_mwe) begin
            for (int k = 0; k < 4; k++) if (a_mbe[k]) w[8*k +: 8] = a_mwd[8*k +: 8];
            mem_a[ad] = w;
        end
    end
    assign a_mrd = pipe_a;

    // Read-first memory with 3-cycle read latency for the second instance.
    always @(posedge clk) begin
        logic [31:0] w;
        int          ad;
        ad = int'(b_maddr[7:0]);
        w  = mem_b.exists(ad) ? mem_b[ad] : init_word(ad);
        pipe_b[0] <= (b_men != 4'h0) ? w : 32'h0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (b_men != 4'h0 && b_mwe) begin
            for (int k = 0; k < 4; k++) if (b_mbe[k]) w[8*k +: 8] = b_mwd[8*k +: 8];
            mem_b[ad] = w;
        end
    end
    assign b_mrd = pipe_b[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: predict, sample at negedge, compare, advance the model.
    task automatic step();
        int          g;
        int          ad;
        logic        s;
        logic [1:0]  e_ready, e_rv1, e_rv3;
        logic [15:0] e_addr;
        logic [31:0] e_wd, e_rd1, e_rd3, d;
        logic        e_we;
        logic [3:0]  e_be;
        if (rst) begin
            q1.delete();
            q3.delete();
            ptr = 0;
        end
        g = -1;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                s = 1'((ptr + k) % 2);
                if (g < 0 && v[s]) g = (ptr + k) % 2;
            end
        end
        e_ready = '0; e_addr = '0; e_wd = '0; e_we = 1'b0; e_be = '0;
        if (g >= 0) begin
            s = 1'(g);
            e_ready[s] = 1'b1;
            e_addr = addr[s]; e_wd = wd[s]; e_we = we[s]; e_be = be[s];
        end
        e_rv1 = '0; e_rd1 = '0; e_rv3 = '0; e_rd3 = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e_rv1[1'(q1[0].id)] = 1'b1; e_rd1 = q1[0].data;
        end
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e_rv3[1'(q3[0].id)] = 1'b1; e_rd3 = q3[0].data;
        end
        @(negedge clk);
        obs_ar = a_ready; obs_arv = a_rv; obs_ard = a_rdata; obs_brv = b_rv;
        obs_amen = a_men; obs_ambe = a_mbe; obs_amwe = a_mwe;
        check_eq("l1_ready", 64'(a_ready), 64'(e_ready));
        check_eq("l1_mem_addr", 64'(a_maddr), 64'(e_addr));
        check_eq("l1_mem_wdata", 64'(a_mwd), 64'(e_wd));
        check_eq("l1_mem_we", 64'(a_mwe), 64'(e_we));
        check_eq("l1_mem_be", 64'(a_mbe), 64'(e_be));
        check_eq("l1_mem_en", 64'(a_men), 64'(e_be));
        check_eq("l1_rsp_valid", 64'(a_rv), 64'(e_rv1));
        check_eq("l1_rsp_data", 64'(a_rdata), 64'(e_rd1));
        check_eq("l3_ready", 64'(b_ready), 64'(e_ready));
        check_eq("l3_mem_addr", 64'(b_maddr), 64'(e_addr));
        check_eq("l3_mem_wdata", 64'(b_mwd), 64'(e_wd));
        check_eq("l3_mem_we", 64'(b_mwe), 64'(e_we));
        check_eq("l3_mem_be", 64'(b_mbe), 64'(e_be));
        check_eq("l3_mem_en", 64'(b_men), 64'(e_be));
        check_eq("l3_rsp_valid", 64'(b_rv), 64'(e_rv3));
        check_eq("l3_rsp_data", 64'(b_rdata), 64'(e_rd3));
        if (q1.size() > 0 && q1[0].due == cyc) void'(q1.pop_front());
        if (q3.size() > 0 && q3[0].due == cyc) void'(q3.pop_front());
        if (g >= 0) begin
            s  = 1'(g);
            ad = int'(addr[s][7:0]);
            d  = shadow.exists(ad) ? shadow[ad] : init_word(ad);
            if (!we[s]) begin
                q1.push_back('{due: cyc + 1, id: g, data: d});
                q3.push_back('{due: cyc + 3, id: g, data: d});
            end else begin
                for (int k = 0; k < 4; k++) if (be[s][k]) d[8*k +: 8] = wd[s][8*k +: 8];
                shadow[ad] = d;
            end
            ptr = (g + 1) % 2;
        end
        last_g = g;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int i, input logic w, input int a, input logic [31:0] data, input logic [3:0] b);
        logic s;
        s = 1'(i);
        v[s] = 1'b1; we[s] = w; addr[s] = 16'(a); wd[s] = data; be[s] = b;
    endtask

    // New random request per requester unless it is still waiting for a grant.
    task automatic gen_random();
        logic s;
        for (int i = 0; i < 2; i++) begin
            s = 1'(i);
            if (!(v[s] && last_g != i)) begin
                v[s]    = ($urandom_range(0, 9) < 6);
                we[s]   = ($urandom_range(0, 2) == 0);
                addr[s] = 16'($urandom_range(0, 31));
                wd[s]   = $urandom;
                be[s]   = 4'($urandom_range(1, 15));
            end
        end
    endtask

    initial begin
        logic [31:0] iw;
        n_chk = 0; n_err = 0; ptr = 0; cyc = 0; last_g = -1;
        rst = 1'b1; v = '0; addr = '0; we = '0; wd = '0; be = '0;
        step();
        check_eq("rst_ready", 64'(obs_ar), 64'h0);
        check_eq("rst_mem_en", 64'(obs_amen), 64'h0);
        step();
        rst = 1'b0;

        set_req(0, 1'b0, 16'h0010, 32'h0, 4'hF);
        step();
        check_eq("rd_ready", 64'(obs_ar), 64'h1);
        check_eq("rd_mem_en", 64'(obs_amen), 64'hF);
        v = '0;
        step();
        check_eq("rd_rsp_valid", 64'(obs_arv), 64'h1);
        check_eq("rd_rsp_data", 64'(obs_ard), 64'hDEADBEEF);

        set_req(1, 1'b1, 16'h0020, 32'h12345678, 4'b0011);
        step();
        check_eq("wr_mem_we", 64'(obs_amwe), 64'h1);
        check_eq("wr_mem_be", 64'(obs_ambe), 64'h3);
        v = '0;
        step();
        check_eq("wr_no_rsp", 64'(obs_arv), 64'h0);
        set_req(1, 1'b0, 16'h0020, 32'h0, 4'hF);
        step();
        v = '0;
        step();
        iw = init_word(32);
        check_eq("wr_rd_low", 64'(obs_ard[15:0]), 64'h5678);
        check_eq("wr_rd_high", 64'(obs_ard[31:16]), 64'(iw[31:16]));

        set_req(0, 1'b0, 3, 32'h0, 4'hF);
        set_req(1, 1'b0, 4, 32'h0, 4'hF);
        for (int n = 0; n < 6; n++) begin
            step();
            check_eq("alt_grant", 64'(obs_ar), (n % 2 == 0) ? 64'h1 : 64'h2);
            if (n > 0) check_eq("alt_rsp", 64'(obs_arv), (n % 2 == 0) ? 64'h2 : 64'h1);
        end
        v = 2'b01;
        step();
        v = '0;
        step();

        set_req(0, 1'b0, 7, 32'h0, 4'hF);
        step();
        v = '0;
        set_req(1, 1'b0, 8, 32'h0, 4'hF);
        step();
        v = '0;
        for (int n = 2; n < 6; n++) begin
            step();
            check_eq("l3_order", 64'(obs_brv), (n == 3) ? 64'h1 : (n == 4) ? 64'h2 : 64'h0);
        end

        set_req(0, 1'b0, 9, 32'h0, 4'hF);
        step();
        rst = 1'b1; v = '0;
        step();
        check_eq("midrst_ready", 64'(obs_ar), 64'h0);
        check_eq("midrst_mem_en", 64'(obs_amen), 64'h0);
        check_eq("midrst_rsp", 64'(obs_arv), 64'h0);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("postrst_l1_rsp", 64'(obs_arv), 64'h0);
            check_eq("postrst_l3_rsp", 64'(obs_brv), 64'h0);
        end

        set_req(0, 1'b0, 1, 32'h0, 4'hF);
        set_req(1, 1'b0, 2, 32'h0, 4'hF);
        step();
        check_eq("ptr_after_rst", 64'(obs_ar), 64'h1);
        step();
        check_eq("second_grant", 64'(obs_ar), 64'h2);
        v = 2'b01;
        step();
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("lone_grant", 64'(obs_ar), 64'h1);
        end
        v = '0;
        step();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1; v = '0;
                step();
                rst = 1'b0;
            end else begin
                gen_random();
                step();
            end
        end
        v = '0;
        for (int n = 0; n < 4; n++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
